// File: rtl/raster_types_pkg.sv
// Shared raster types: stamp and CSR bank layouts, CSR address map and pos_mask packing.
// Used by raster_csr_responder (optional perf counters: RASTER_CSR_PERF_EN).
package raster_types_pkg;

   localparam int RASTER_DIM_BITS = 12;
   localparam int RASTER_PID_BITS = 8;

   localparam logic [3:0] RASTER_CSR_ADDR_POS_MASK = 4'd0;
   localparam logic [3:0] RASTER_CSR_ADDR_BCX      = 4'd1;
   localparam logic [3:0] RASTER_CSR_ADDR_BCY      = 4'd5;
   localparam logic [3:0] RASTER_CSR_ADDR_BCZ      = 4'd9;
   localparam logic [3:0] RASTER_CSR_ADDR_PID      = 4'd13;

   // bcoords[0] holds x, [1] y, [2] z; each has four 32-bit coefficients.
   typedef struct packed {
      logic [RASTER_DIM_BITS-2:0] pos_x;
      logic [RASTER_DIM_BITS-2:0] pos_y;
      logic [3:0]                 mask;
      logic [2:0][3:0][31:0]      bcoords;
      logic [RASTER_PID_BITS-1:0] pid;
   } raster_stamp_t;

   typedef struct packed {
      logic [31:0]           pos_mask;
      logic [2:0][3:0][31:0] bcoords;
   } raster_csrs_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RSP  = 1'b1
   } rsp_state_e;

   // pos_x and pos_y arrive zero-extended; each occupies dim_bits-1 bits.
   function automatic logic [31:0] raster_pack_pos_mask(input logic [31:0] pos_x,
                                                        input logic [31:0] pos_y,
                                                        input logic [3:0]  mask,
                                                        input int          dim_bits);
      return {28'd0, mask} | (pos_x << 4) | (pos_y << (dim_bits + 3));
   endfunction

endpackage

// File: rtl/raster_csr_responder_fifo.sv
// Generic power-of-two FIFO queue (VX_fifo_queue style) used as the stamp buffer.
// Caller guarantees no push when full and no pop when empty.
module raster_csr_responder_fifo #(
   parameter int DATAW = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out,
   output logic             empty,
   output logic             full
);

   localparam int ADDRW = $clog2(DEPTH);

   logic [DATAW-1:0] mem [DEPTH];
   logic [ADDRW-1:0] rd_ptr;
   logic [ADDRW-1:0] wr_ptr;
   logic [ADDRW:0]   count;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   assign data_out = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == (ADDRW+1)'(DEPTH));

endmodule

// File: rtl/raster_csr_responder.sv
// Raster stamp consumer: buffers stamps, loads one into the CSR bank per core fetch,
// and serves registered CSR reads. Optional perf counters under RASTER_CSR_PERF_EN.
module raster_csr_responder import raster_types_pkg::*; #(
   parameter int FIFO_DEPTH = 4,
   parameter int DIM_BITS   = RASTER_DIM_BITS,
   parameter int PID_BITS   = RASTER_PID_BITS
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              stamp_valid,
   input  logic [$bits(raster_stamp_t)-1:0]  stamp_data,
   output logic                              stamp_ready,
   input  logic                              stamp_done,
   input  logic                              fetch_valid,
   output logic                              fetch_ready,
   output logic                              fetch_rsp_valid,
   output logic                              fetch_rsp_empty,
   input  logic                              csr_read_valid,
   input  logic [3:0]                        csr_read_addr,
   output logic                              csr_read_rsp_valid,
   output logic [31:0]                       csr_read_data
`ifdef RASTER_CSR_PERF_EN
   ,
   output logic [31:0]                       perf_fetches,
   output logic [31:0]                       perf_stall_cycles
`endif
);

   logic [$bits(raster_stamp_t)-1:0] fifo_dout;
   raster_stamp_t head;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          load_empty;
   rsp_state_e    state;
   rsp_state_e    state_next;
   raster_csrs_t  bank;
   logic [PID_BITS-1:0] bank_pid;
   logic          rsp_empty_q;
   logic [31:0]   rd_mux;

   // Ready is gated by reset so every output reads 0 while reset is held.
   assign stamp_ready = reset & ~fifo_full;
   assign push        = stamp_valid & stamp_ready;
   assign head        = raster_stamp_t'(fifo_dout);

   raster_csr_responder_fifo #(
      .DATAW (($bits(raster_stamp_t))),
      .DEPTH (FIFO_DEPTH)
   ) stamp_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .data_in  (stamp_data),
      .data_out (fifo_dout),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      fetch_ready = 1'b0;
      pop         = 1'b0;
      load_empty  = 1'b0;
      case (state)
         ST_IDLE: begin
            fetch_ready = reset & (~fifo_empty | stamp_done);
            if (fetch_valid && fetch_ready) begin
               state_next = ST_RSP;
               pop        = ~fifo_empty;
               load_empty = fifo_empty;
            end
         end
         ST_RSP:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign fetch_rsp_valid = (state == ST_RSP);
   assign fetch_rsp_empty = fetch_rsp_valid & rsp_empty_q;

   // End-of-draw clears only pos_mask; bcoords and pid keep the last stamp.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank        <= '0;
         bank_pid    <= '0;
         rsp_empty_q <= 1'b0;
      end else if (pop) begin
         bank.pos_mask <= raster_pack_pos_mask(32'(head.pos_x), 32'(head.pos_y), head.mask, DIM_BITS);
         bank.bcoords  <= head.bcoords;
         bank_pid      <= PID_BITS'(head.pid);
         rsp_empty_q   <= 1'b0;
      end else if (load_empty) begin
         bank.pos_mask <= '0;
         rsp_empty_q   <= 1'b1;
      end
   end

   always_comb begin
      rd_mux = '0;
      if (csr_read_addr == RASTER_CSR_ADDR_POS_MASK)
         rd_mux = bank.pos_mask;
      else if (csr_read_addr < RASTER_CSR_ADDR_BCY)
         rd_mux = bank.bcoords[0][2'(csr_read_addr - RASTER_CSR_ADDR_BCX)];
      else if (csr_read_addr < RASTER_CSR_ADDR_BCZ)
         rd_mux = bank.bcoords[1][2'(csr_read_addr - RASTER_CSR_ADDR_BCY)];
      else if (csr_read_addr < RASTER_CSR_ADDR_PID)
         rd_mux = bank.bcoords[2][2'(csr_read_addr - RASTER_CSR_ADDR_BCZ)];
      else if (csr_read_addr == RASTER_CSR_ADDR_PID)
         rd_mux = 32'(bank_pid);
   end

   // Sampling the bank before its update gives pre-load data on a same-cycle fetch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csr_read_rsp_valid <= 1'b0;
         csr_read_data      <= '0;
      end else begin
         csr_read_rsp_valid <= csr_read_valid;
         if (csr_read_valid) csr_read_data <= rd_mux;
      end
   end

`ifdef RASTER_CSR_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetches      <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (pop) perf_fetches <= perf_fetches + 32'd1;
         if (state == ST_IDLE && fetch_valid && !fetch_ready)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_raster_csr_responder.sv
// Directed and random bench for raster_csr_responder against a queue-based reference model.
// Also checks the perf counters when RASTER_CSR_PERF_EN is defined.
module tb_raster_csr_responder;
   import raster_types_pkg::*;

   localparam int DEPTH = 4;
   localparam int SW    = $bits(raster_stamp_t);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          stamp_valid = 1'b0;
   logic [SW-1:0] stamp_data = '0;
   logic          stamp_ready;
   logic          stamp_done = 1'b0;
   logic          fetch_valid = 1'b0;
   logic          fetch_ready;
   logic          fetch_rsp_valid;
   logic          fetch_rsp_empty;
   logic          csr_read_valid = 1'b0;
   logic [3:0]    csr_read_addr = '0;
   logic          csr_read_rsp_valid;
   logic [31:0]   csr_read_data;
`ifdef RASTER_CSR_PERF_EN
   logic [31:0]   perf_fetches;
   logic [31:0]   perf_stall_cycles;
   int            m_fetches = 0;
   int            m_stalls = 0;
`endif

   always #5 clk = ~clk;

   raster_csr_responder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk                (clk),
      .reset              (reset),
      .stamp_valid        (stamp_valid),
      .stamp_data         (stamp_data),
      .stamp_ready        (stamp_ready),
      .stamp_done         (stamp_done),
      .fetch_valid        (fetch_valid),
      .fetch_ready        (fetch_ready),
      .fetch_rsp_valid    (fetch_rsp_valid),
      .fetch_rsp_empty    (fetch_rsp_empty),
      .csr_read_valid     (csr_read_valid),
      .csr_read_addr      (csr_read_addr),
      .csr_read_rsp_valid (csr_read_rsp_valid),
      .csr_read_data      (csr_read_data)
`ifdef RASTER_CSR_PERF_EN
      ,
      .perf_fetches       (perf_fetches),
      .perf_stall_cycles  (perf_stall_cycles)
`endif
   );

   int errors = 0;
   int checks = 0;

   raster_stamp_t q[$];
   logic [31:0]   m_csr [16];
   logic          m_rsp = 1'b0;
   logic          m_rsp_empty = 1'b0;
   logic          m_rd_valid = 1'b0;
   logic [31:0]   m_rd_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic raster_stamp_t rand_stamp();
      raster_stamp_t s;
      s.pos_x = (RASTER_DIM_BITS-1)'($urandom);
      s.pos_y = (RASTER_DIM_BITS-1)'($urandom);
      s.mask  = 4'($urandom);
      s.pid   = RASTER_PID_BITS'($urandom);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 4; j++)
            s.bcoords[i][j] = $urandom;
      return s;
   endfunction

   function automatic logic exp_stamp_ready();
      return reset && (q.size() < DEPTH);
   endfunction

   function automatic logic exp_fetch_ready();
      return reset && !m_rsp && (q.size() > 0 || stamp_done);
   endfunction

   task automatic model_reset();
      q.delete();
      m_rsp       = 1'b0;
      m_rsp_empty = 1'b0;
      m_rd_valid  = 1'b0;
      m_rd_data   = '0;
      for (int i = 0; i < 16; i++) m_csr[i] = '0;
   endtask

   // Bank image from the stamp: mask, then pos_x, then pos_y, each field above the previous one.
   task automatic model_load(input raster_stamp_t s);
      m_csr[0] = 32'(s.mask) + 32'(s.pos_x) * 32'd16 + 32'(s.pos_y) * (32'd1 << (RASTER_DIM_BITS + 3));
      for (int j = 0; j < 4; j++) begin
         m_csr[1 + j] = s.bcoords[0][j];
         m_csr[5 + j] = s.bcoords[1][j];
         m_csr[9 + j] = s.bcoords[2][j];
      end
      m_csr[13] = 32'(s.pid);
   endtask

   task automatic check_outputs();
      chk("stamp_ready", 32'(stamp_ready), 32'(exp_stamp_ready()));
      chk("fetch_ready", 32'(fetch_ready), 32'(exp_fetch_ready()));
      chk("fetch_rsp_valid", 32'(fetch_rsp_valid), 32'(m_rsp));
      chk("fetch_rsp_empty", 32'(fetch_rsp_empty), 32'(m_rsp && m_rsp_empty));
      chk("csr_read_rsp_valid", 32'(csr_read_rsp_valid), 32'(m_rd_valid));
      chk("csr_read_data", csr_read_data, m_rd_data);
   endtask

   // Check this cycle's outputs, predict the clock edge, then advance one cycle.
   task automatic tick();
      logic push, accept;
      #1;
      check_outputs();
      push   = stamp_valid && exp_stamp_ready();
      accept = fetch_valid && exp_fetch_ready();
`ifdef RASTER_CSR_PERF_EN
      if (reset && !m_rsp && fetch_valid && !accept) m_stalls++;
      if (accept && q.size() > 0) m_fetches++;
`endif
      if (reset && csr_read_valid) begin
         m_rd_valid = 1'b1;
         m_rd_data  = m_csr[csr_read_addr];
      end else begin
         m_rd_valid = 1'b0;
      end
      if (accept) begin
         if (q.size() > 0) begin
            model_load(q.pop_front());
            m_rsp_empty = 1'b0;
         end else begin
            m_csr[0]    = '0;
            m_rsp_empty = 1'b1;
         end
      end
      m_rsp = accept;
      if (push) q.push_back(raster_stamp_t'(stamp_data));
      @(posedge clk);
      #1;
      if (!reset) model_reset();
   endtask

   task automatic push_stamp(input raster_stamp_t s);
      stamp_valid = 1'b1;
      stamp_data  = s;
      tick();
      stamp_valid = 1'b0;
   endtask

   task automatic fetch(input string tag, input logic exp_empty);
      fetch_valid = 1'b1;
      tick();
      fetch_valid = 1'b0;
      chk({tag, "_rsp_valid"}, 32'(fetch_rsp_valid), 32'd1);
      chk({tag, "_rsp_empty"}, 32'(fetch_rsp_empty), 32'(exp_empty));
      tick();
   endtask

   task automatic read_csr(input logic [3:0] addr, output logic [31:0] data);
      csr_read_valid = 1'b1;
      csr_read_addr  = addr;
      tick();
      csr_read_valid = 1'b0;
      data = csr_read_data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      raster_stamp_t s;
      logic [31:0]   rd;
      logic [31:0]   old_pm;

      model_reset();
      // Reset state with hostile inputs.
      stamp_done  = 1'b1;
      fetch_valid = 1'b1;
      stamp_valid = 1'b1;
      #2;
      chk("rst_stamp_ready", 32'(stamp_ready), 32'd0);
      chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
      chk("rst_rsp_valid", 32'(fetch_rsp_valid), 32'd0);
      chk("rst_rsp_empty", 32'(fetch_rsp_empty), 32'd0);
      chk("rst_read_valid", 32'(csr_read_rsp_valid), 32'd0);
      chk("rst_read_data", csr_read_data, 32'd0);
      stamp_done  = 1'b0;
      fetch_valid = 1'b0;
      stamp_valid = 1'b0;
      @(posedge clk);
      #1;
      tick();
      reset = 1'b1;
      tick();

      // Single directed stamp.
      s = '0;
      s.pos_x = 11'd5;
      s.pos_y = 11'd3;
      s.mask  = 4'b1011;
      s.pid   = 8'd7;
      s.bcoords[0][2] = 32'h3F80_0000;
      push_stamp(s);
      fetch("t1", 1'b0);
      read_csr(4'd0, rd);
      chk("t1_pos_mask", rd, 32'h0001_805B);
      read_csr(4'd3, rd);
      chk("t1_bcx2", rd, 32'h3F80_0000);
      read_csr(4'd13, rd);
      chk("t1_pid", rd, 32'd7);
      read_csr(4'd14, rd);
      chk("t1_addr14", rd, 32'd0);

      // Fill the FIFO, hold a fifth stamp, free one slot by a fetch.
      stamp_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         stamp_data = rand_stamp();
         tick();
      end
      stamp_data = rand_stamp();
      chk("full_ready", 32'(stamp_ready), 32'd0);
      repeat (3) tick();
      fetch_valid = 1'b1;
      #1;
      chk("full_pop_cycle_ready", 32'(stamp_ready), 32'd0);
      tick();
      fetch_valid = 1'b0;
      chk("after_pop_ready", 32'(stamp_ready), 32'd1);
      tick();
      stamp_valid = 1'b0;
      chk("refull_ready", 32'(stamp_ready), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         fetch("drain", 1'b0);
         read_csr(4'($urandom_range(0, 13)), rd);
      end

      // Empty FIFO without stamp_done stalls; stamp_done ends the draw.
      fetch_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("stall_fetch_ready", 32'(fetch_ready), 32'd0);
         tick();
      end
      stamp_done = 1'b1;
      #1;
      chk("done_fetch_ready", 32'(fetch_ready), 32'd1);
      tick();
      fetch_valid = 1'b0;
      chk("done_rsp_empty", 32'(fetch_rsp_empty), 32'd1);
      tick();
      read_csr(4'd0, rd);
      chk("done_pos_mask", rd, 32'd0);
      stamp_done = 1'b0;

      // Buffered stamps are served before end-of-draw is reported.
      push_stamp(rand_stamp());
      push_stamp(rand_stamp());
      stamp_done = 1'b1;
      fetch("drain2_a", 1'b0);
      read_csr(4'd0, rd);
      fetch("drain2_b", 1'b0);
      read_csr(4'd0, rd);
      fetch("drain2_c", 1'b1);
      stamp_done = 1'b0;

      // Read racing a fetch load sees the old bank.
      push_stamp(rand_stamp());
      fetch("race_pre", 1'b0);
      push_stamp(rand_stamp());
      old_pm = m_csr[0];
      fetch_valid    = 1'b1;
      csr_read_valid = 1'b1;
      csr_read_addr  = 4'd0;
      tick();
      fetch_valid    = 1'b0;
      csr_read_valid = 1'b0;
      chk("race_old_pos_mask", csr_read_data, old_pm);
      read_csr(4'd0, rd);
      chk("race_new_pos_mask", rd, m_csr[0]);

      // Reset mid-operation with stamps buffered and a response pending.
      for (int i = 0; i < 4; i++) push_stamp(rand_stamp());
      read_csr(4'd1, rd);
      fetch_valid = 1'b1;
      tick();
      fetch_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("mid_rst_stamp_ready", 32'(stamp_ready), 32'd0);
      chk("mid_rst_fetch_ready", 32'(fetch_ready), 32'd0);
      chk("mid_rst_rsp_valid", 32'(fetch_rsp_valid), 32'd0);
      chk("mid_rst_rsp_empty", 32'(fetch_rsp_empty), 32'd0);
      chk("mid_rst_read_valid", 32'(csr_read_rsp_valid), 32'd0);
      chk("mid_rst_read_data", csr_read_data, 32'd0);
      model_reset();
      tick();
      tick();
      reset = 1'b1;
      fetch_valid = 1'b1;
      repeat (3) begin
         #1;
         chk("post_rst_stall", 32'(fetch_ready), 32'd0);
         tick();
      end
      fetch_valid = 1'b0;

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         stamp_valid    = 1'($urandom_range(0, 1));
         stamp_data     = rand_stamp();
         fetch_valid    = ($urandom_range(0, 2) == 0);
         stamp_done     = ($urandom_range(0, 7) == 0);
         csr_read_valid = 1'($urandom_range(0, 1));
         csr_read_addr  = 4'($urandom_range(0, 15));
         tick();
      end
      stamp_valid    = 1'b0;
      fetch_valid    = 1'b0;
      csr_read_valid = 1'b0;
      tick();

`ifdef RASTER_CSR_PERF_EN
      chk("perf_fetches", perf_fetches, 32'(m_fetches));
      chk("perf_stall_cycles", perf_stall_cycles, 32'(m_stalls));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
